consecutive_run_detector: RTL and testbench

Sequential, parametrised run detector for a serial bit stream. It flags when `RUN_LEN` consecutive equal bits arrive, with run-time selection of polarity (zeros, ones or either). This is the next generation of the team's fixed three-bit, four-input combinational zeros/ones detector. It sits behind a serialiser or line decoder and feeds the line-quality and framing-alarm logic.

---
 rtl/consecutive_run_detector.sv | 104 ++++++++++
 tb/tb_consecutive_run_detector.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/consecutive_run_detector.sv
// Serial run detector: flags RUN_LEN equal bits in a row, polarity by mode.
// Optional detection counter enabled by defining CRD_EVENT_COUNT_EN.
module consecutive_run_detector #(
  parameter int RUN_LEN   = 3,
  parameter int RETRIGGER = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [1:0]       mode,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             z,
  output logic             z_bit,
  output logic [7:0]       run_len,
  output logic [CNT_W-1:0] det_count
);

  typedef enum logic {EMPTY, TRACK} state_t;

  localparam logic [7:0] RL = 8'(RUN_LEN);

  state_t     state_q, state_d, base_st;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d, base_cnt;
  logic       z_d, zb_d;
  logic       restart, match, fresh;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    z_d      = 1'b0;
    zb_d     = z_bit;
    restart  = 1'b0;
    match    = 1'b0;
    fresh    = 1'b0;
    // flush takes effect before a same-cycle bit
    base_st  = flush ? EMPTY : state_q;
    base_cnt = flush ? 8'd0 : cnt_q;
    if (flush) begin
      state_d = EMPTY;
      cnt_d   = 8'd0;
    end
    if (in_valid) begin
      restart = (base_st == EMPTY) || (in_bit != last_q);
      if (restart)
        cnt_d = 8'd1;
      else if (base_cnt >= RL)
        cnt_d = RL;
      else
        cnt_d = base_cnt + 8'd1;
      last_d  = in_bit;
      state_d = TRACK;
      match   = mode[1] | (mode[0] == in_bit);
      fresh   = restart || (base_cnt < RL) ||
                (RETRIGGER != 0) || (RUN_LEN == 1);
      if ((cnt_d == RL) && fresh && match) begin
        z_d  = 1'b1;
        zb_d = in_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q  <= 1'b0;
      cnt_q   <= 8'd0;
      z       <= 1'b0;
      z_bit   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      z       <= z_d;
      z_bit   <= zb_d;
    end
  end

  assign run_len = cnt_q;

`ifdef CRD_EVENT_COUNT_EN
  logic [CNT_W-1:0] dc_q;

  always_ff @(posedge clk) begin
    if (rst)
      dc_q <= '0;
    else if (cnt_clr)
      dc_q <= CNT_W'(z_d);
    else if (z_d && (dc_q != {CNT_W{1'b1}}))
      dc_q <= dc_q + 1'b1;
  end

  assign det_count = dc_q;
`else
  logic unused_clr;
  assign unused_clr = cnt_clr;
  assign det_count  = '0;
`endif

endmodule

// File: tb/tb_consecutive_run_detector.sv
// Scoreboard bench: three detector configurations share one stimulus
// stream; a history-queue reference model predicts every cycle's outputs.
module tb_consecutive_run_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_bit, flush, cnt_clr;
  logic [1:0] mode;

  logic       z0, z1, z2, zb0, zb1, zb2;
  logic [7:0] rl0, rl1, rl2;
  logic [7:0] dc0;
  logic [1:0] dc1, dc2;

  consecutive_run_detector #(.RUN_LEN(3), .RETRIGGER(0), .CNT_W(8)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .mode(mode), .flush(flush), .cnt_clr(cnt_clr),
    .z(z0), .z_bit(zb0), .run_len(rl0), .det_count(dc0));

  consecutive_run_detector #(.RUN_LEN(3), .RETRIGGER(1), .CNT_W(2)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .mode(mode), .flush(flush), .cnt_clr(cnt_clr),
    .z(z1), .z_bit(zb1), .run_len(rl1), .det_count(dc1));

  consecutive_run_detector #(.RUN_LEN(1), .RETRIGGER(0), .CNT_W(2)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .mode(mode), .flush(flush), .cnt_clr(cnt_clr),
    .z(z2), .z_bit(zb2), .run_len(rl2), .det_count(dc2));

  typedef struct packed {
    logic [2:0]      z;
    logic [2:0]      zb;
    logic [2:0][7:0] rl;
    logic [2:0][7:0] dc;
  } exp_t;

  exp_t exq[$];
  bit   hist[$];

  int prl[3]  = '{3, 3, 1};
  int pret[3] = '{0, 1, 0};
  int cmax[3] = '{255, 3, 3};
  int mzb[3];
  int mdc[3];

  int checks = 0;
  int errors = 0;

  function automatic int trail();
    int n;
    n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  // Drive one cycle of inputs, predict the post-edge outputs, then wait.
  task automatic step(input bit r, input bit v, input bit b,
                      input bit [1:0] m, input bit f, input bit c);
    exp_t e;
    int   l;
    bit   ez;
    rst = r; in_valid = v; in_bit = b;
    mode = m; flush = f; cnt_clr = c;
    e = '0;
    if (r) begin
      hist.delete();
      for (int k = 0; k < 3; k++) begin
        mzb[k] = 0;
        mdc[k] = 0;
      end
    end else begin
      if (f) hist.delete();
      if (v) hist.push_back(b);
      l = trail();
      for (int k = 0; k < 3; k++) begin
        ez = v && (l >= prl[k]) &&
             (l == prl[k] || pret[k] != 0 || prl[k] == 1) &&
             (m[1] || (m[0] == b));
        if (ez) mzb[k] = int'(b);
`ifdef CRD_EVENT_COUNT_EN
        if (c) mdc[k] = ez ? 1 : 0;
        else if (ez && mdc[k] < cmax[k]) mdc[k]++;
`endif
        e.z[k]  = ez;
        e.rl[k] = 8'((l < prl[k]) ? l : prl[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      e.zb[k] = mzb[k][0];
      e.dc[k] = 8'(mdc[k]);
    end
    exq.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exq.size() > 0) begin
        e = exq.pop_front();
        chk("z0", {7'd0, z0}, {7'd0, e.z[0]});
        chk("z1", {7'd0, z1}, {7'd0, e.z[1]});
        chk("z2", {7'd0, z2}, {7'd0, e.z[2]});
        chk("zb0", {7'd0, zb0}, {7'd0, e.zb[0]});
        chk("zb1", {7'd0, zb1}, {7'd0, e.zb[1]});
        chk("zb2", {7'd0, zb2}, {7'd0, e.zb[2]});
        chk("rl0", rl0, e.rl[0]);
        chk("rl1", rl1, e.rl[1]);
        chk("rl2", rl2, e.rl[2]);
        chk("dc0", dc0, e.dc[0]);
        chk("dc1", {6'd0, dc1}, e.dc[1]);
        chk("dc2", {6'd0, dc2}, e.dc[2]);
      end
    end
  end

  initial begin : driver
    bit b, v, prev;
    bit [1:0] m;
    step(1, 0, 0, 2'b00, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0);
    // zeros run: 1,0,0,0
    step(0, 1, 1, 2'b00, 0, 0);
    step(0, 1, 0, 2'b00, 0, 0);
    step(0, 1, 0, 2'b00, 0, 0);
    step(0, 1, 0, 2'b00, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0);
    // ones run with retrigger difference: 0,1,1,1,1,1
    step(0, 1, 0, 2'b01, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 2'b01, 0, 0);
    // alternating then a run of ones, either polarity
    for (int i = 0; i < 4; i++) step(0, 1, ~i[0], 2'b10, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 2'b11, 0, 0);
    // flush alone, then flush with a concurrent bit
    step(0, 1, 0, 2'b00, 0, 0);
    step(0, 1, 0, 2'b00, 0, 0);
    step(0, 0, 0, 2'b00, 1, 0);
    step(0, 1, 0, 2'b00, 0, 0);
    step(0, 1, 0, 2'b00, 1, 0);
    step(0, 1, 0, 2'b00, 1, 0);
    step(0, 1, 0, 2'b00, 0, 0);
    // counter saturation and clear coincident with z
    for (int i = 0; i < 5; i++) step(0, 1, i[0], 2'b11, 0, 0);
    step(0, 1, 1, 2'b11, 0, 1);
    step(0, 0, 1, 2'b11, 0, 1);
    // reset on the completing bit
    step(0, 1, 0, 2'b00, 0, 0);
    step(0, 1, 0, 2'b00, 0, 0);
    step(1, 1, 0, 2'b00, 1, 1);
    step(0, 0, 0, 2'b00, 0, 0);
    // randomized stream biased towards runs
    prev = 0;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 8);
      b = ($urandom_range(0, 9) < 7) ? prev : ~prev;
      m = 2'($urandom_range(0, 3));
      if (v) prev = b;
      step(($urandom_range(0, 199) == 0), v, b, m,
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0));
    end
    step(0, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 10 && exq.size() > 0; i++) @(negedge clk);
    if (exq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
